// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory path.
// Contents:
//   - funct3 encodings for RV32I loads and stores
//   - dcache_state_t : data cache controller states
//   - strb_t         : 4-lane byte-enable type
//   - store_strb     : byte enables for a store of a given size and offset
//   - store_wdata    : store data replicated into every lane it may occupy
//   - merge_bytes    : overlay the enabled lanes of a new word onto an old word
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2
    } dcache_state_t;

    typedef logic [3:0] strb_t;

    function automatic strb_t store_strb(input logic [2:0] f3, input logic [1:0] off);
        strb_t s;
        case (f3)
            F3_B:    s = strb_t'(4'b0001 << off);
            F3_H:    s = strb_t'(4'b0011 << {off[1], 1'b0});
            default: s = 4'b1111;
        endcase
        return s;
    endfunction

    function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] d;
        case (f3)
            F3_B:    d = {4{wd[7:0]}};
            F3_H:    d = {2{wd[15:0]}};
            default: d = wd;
        endcase
        return d;
    endfunction

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input strb_t       strb);
        logic [31:0] m;
        m = old_word;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) begin
                m[8*i +: 8] = new_word[8*i +: 8];
            end else begin
                m[8*i +: 8] = old_word[8*i +: 8];
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/load_extend.sv
// Load result extraction and extension for RV32I loads.
// Ports:
//   word   in  32 : aligned memory word containing the addressed data
//   offset in  2  : byte offset within the word (addr[1:0])
//   funct3 in  3  : load size/sign (B, H, W, BU, HU)
//   result out 32 : extended load value; zero for unsupported funct3
// Misaligned halfwords are not trapped: the half lane is chosen by offset[1]
// alone, and word loads ignore the offset entirely.
import mem_pkg::*;

module load_extend (
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane selection followed by sign or zero extension.
    always_comb begin
        byte_s = 8'h00;
        half_s = 16'h0000;
        result = 32'h0000_0000;

        case (offset)
            2'd0:    byte_s = word[7:0];
            2'd1:    byte_s = word[15:8];
            2'd2:    byte_s = word[23:16];
            2'd3:    byte_s = word[31:24];
            default: byte_s = 8'h00;
        endcase

        if (offset[1]) begin
            half_s = word[31:16];
        end else begin
            half_s = word[15:0];
        end

        case (funct3)
            F3_B:    result = {{24{byte_s[7]}}, byte_s};
            F3_H:    result = {{16{half_s[15]}}, half_s};
            F3_W:    result = word;
            F3_BU:   result = {24'h00_0000, byte_s};
            F3_HU:   result = {16'h0000, half_s};
            default: result = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache with one-word lines.
// Ports:
//   clk, rst                 : clock and synchronous active-high reset
//   req_valid, wr_en         : memory-stage access, store when wr_en=1
//   addr, WriteData, funct3  : byte address, store data, access size/sign
//   ReadData                 : extended load result, zero unless a load completes
//   stall                    : pipeline hold on any miss or store
//   mem_req, mem_we          : backing-memory request and direction (registered)
//   mem_addr, mem_wdata      : word-aligned address and lane-replicated store data
//   mem_wstrb                : byte enables for writes
//   mem_ready, mem_rdata     : backing-memory completion and read word
//   hit_count, miss_count    : load hit and miss counters, wrapping
// Loads that hit complete in the access cycle. Load misses go through FILL and
// stores through WRITE; both keep the pipeline stalled until mem_ready.
import mem_pkg::*;

module data_cache #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int SETS       = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] WriteData,
    input  logic [2:0]            funct3,
    output logic [DATA_WIDTH-1:0] ReadData,
    output logic                  stall,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [3:0]            mem_wstrb,
    input  logic                  mem_ready,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count
);

    localparam int IDX = $clog2(SETS);
    localparam int TAG = ADDR_WIDTH - 2 - IDX;

    dcache_state_t         state_r;
    logic [SETS-1:0]       valid_r;
    logic [TAG-1:0]        tag_r  [SETS];
    logic [DATA_WIDTH-1:0] data_r [SETS];

    logic [IDX-1:0]        req_idx_s;
    logic [TAG-1:0]        req_tag_s;
    logic                  req_hit_s;
    logic [IDX-1:0]        txn_idx_s;
    logic [TAG-1:0]        txn_tag_s;
    logic                  txn_hit_s;
    logic                  load_done_s;
    logic [DATA_WIDTH-1:0] ext_word_s;
    logic [DATA_WIDTH-1:0] ext_result_s;

    // The live request drives lookup in IDLE; the registered mem_addr
    // identifies the line touched when an outstanding transaction completes.
    assign req_idx_s = addr[IDX+1:2];
    assign req_tag_s = addr[ADDR_WIDTH-1:IDX+2];
    assign req_hit_s = valid_r[req_idx_s] && (tag_r[req_idx_s] == req_tag_s);
    assign txn_idx_s = mem_addr[IDX+1:2];
    assign txn_tag_s = mem_addr[ADDR_WIDTH-1:IDX+2];
    assign txn_hit_s = valid_r[txn_idx_s] && (tag_r[txn_idx_s] == txn_tag_s);

    load_extend u_load_extend (
        .word   (ext_word_s),
        .offset (addr[1:0]),
        .funct3 (funct3),
        .result (ext_result_s)
    );

    // Stall and load-completion decode; a fill forwards mem_rdata directly.
    always_comb begin
        stall       = 1'b0;
        load_done_s = 1'b0;
        ext_word_s  = data_r[req_idx_s];
        if (rst) begin
            stall = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_valid && (wr_en || !req_hit_s)) begin
                        stall = 1'b1;
                    end else if (req_valid) begin
                        load_done_s = 1'b1;
                    end else begin
                        stall = 1'b0;
                    end
                end
                FILL: begin
                    if (mem_ready) begin
                        load_done_s = 1'b1;
                        ext_word_s  = mem_rdata;
                    end else begin
                        stall = 1'b1;
                    end
                end
                WRITE: begin
                    if (mem_ready) begin
                        stall = 1'b0;
                    end else begin
                        stall = 1'b1;
                    end
                end
                default: stall = 1'b0;
            endcase
        end
        if (load_done_s) begin
            ReadData = ext_result_s;
        end else begin
            ReadData = '0;
        end
    end

    // Controller: state, valid bits, backing-memory request and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            valid_r    <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wstrb  <= 4'b0000;
            hit_count  <= 32'd0;
            miss_count <= 32'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_valid && wr_en) begin
                        state_r   <= WRITE;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= {addr[ADDR_WIDTH-1:2], 2'b00};
                        mem_wdata <= store_wdata(funct3, WriteData);
                        mem_wstrb <= store_strb(funct3, addr[1:0]);
                    end else if (req_valid && req_hit_s) begin
                        hit_count <= hit_count + 32'd1;
                    end else if (req_valid) begin
                        state_r    <= FILL;
                        mem_req    <= 1'b1;
                        mem_we     <= 1'b0;
                        mem_addr   <= {addr[ADDR_WIDTH-1:2], 2'b00};
                        mem_wstrb  <= 4'b0000;
                        miss_count <= miss_count + 32'd1;
                    end else begin
                        mem_req <= 1'b0;
                    end
                end
                FILL: begin
                    if (mem_ready) begin
                        state_r            <= IDLE;
                        mem_req            <= 1'b0;
                        valid_r[txn_idx_s] <= 1'b1;
                    end else begin
                        state_r <= FILL;
                    end
                end
                WRITE: begin
                    if (mem_ready) begin
                        state_r <= IDLE;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                    end else begin
                        state_r <= WRITE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    mem_req <= 1'b0;
                    mem_we  <= 1'b0;
                end
            endcase
        end
    end

    // Line storage: fills replace tag and data, store hits merge enabled bytes.
    always_ff @(posedge clk) begin
        if (!rst && (state_r == FILL) && mem_ready) begin
            tag_r[txn_idx_s]  <= txn_tag_s;
            data_r[txn_idx_s] <= mem_rdata;
        end else if (!rst && (state_r == WRITE) && mem_ready && txn_hit_s) begin
            data_r[txn_idx_s] <= merge_bytes(data_r[txn_idx_s], mem_wdata, mem_wstrb);
        end
    end

endmodule

// File: tb/tb_data_cache.sv
// Scoreboard bench for data_cache: directed accesses push their expected load
// result and memory transaction; independent monitors pop and compare.
`timescale 1ns/1ps
import mem_pkg::*;

module tb_data_cache;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        wr_en;
    logic [31:0] addr;
    logic [31:0] WriteData;
    logic [2:0]  funct3;
    logic [31:0] ReadData;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } mem_exp_t;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] exp;
    } ld_vec_t;

    logic [31:0] exp_rd_q[$];
    mem_exp_t    exp_mem_q[$];
    logic [31:0] mem [0:1023];
    int          lat = 1;
    int          wait_cnt = 0;
    int          checks = 0;
    int          errors = 0;
    int          exp_hits = 0;
    int          exp_misses = 0;

    data_cache dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .wr_en      (wr_en),
        .addr       (addr),
        .WriteData  (WriteData),
        .funct3     (funct3),
        .ReadData   (ReadData),
        .stall      (stall),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Backing memory: acknowledges after lat waiting cycles, applies strobed writes.
    always @(posedge clk) begin
        #1;
        if (mem_req && !mem_ready && (wait_cnt >= lat)) begin
            mem_ready = 1'b1;
            wait_cnt  = 0;
            if (mem_we) begin
                mem_rdata = 32'h0;
                for (int i = 0; i < 4; i++) begin
                    if (mem_wstrb[i]) mem[mem_addr[11:2]][8*i +: 8] = mem_wdata[8*i +: 8];
                end
            end else begin
                mem_rdata = mem[mem_addr[11:2]];
            end
        end else begin
            mem_ready = 1'b0;
            mem_rdata = 32'h0;
            if (mem_req) wait_cnt++;
            else wait_cnt = 0;
        end
    end

    // Monitor: load results, idle ReadData, and completed memory transactions.
    always @(negedge clk) begin
        if (!rst) begin
            if (req_valid && !wr_en && !stall) begin
                if (exp_rd_q.size() == 0) begin
                    check("unexpected_load", ReadData, 32'hFFFF_FFFF);
                end else begin
                    check("load_data", ReadData, exp_rd_q.pop_front());
                end
            end else begin
                check("readdata_idle_zero", ReadData, 32'h0);
            end
            if (mem_req && mem_ready) begin
                if (exp_mem_q.size() == 0) begin
                    check("unexpected_mem_txn", mem_addr, 32'hFFFF_FFFF);
                end else begin
                    mem_exp_t e;
                    e = exp_mem_q.pop_front();
                    check("mem_we", {31'd0, mem_we}, {31'd0, e.we});
                    check("mem_addr", mem_addr, e.addr);
                    if (e.we) begin
                        check("mem_wdata", mem_wdata, e.wdata);
                        check("mem_wstrb", {28'd0, mem_wstrb}, {28'd0, e.wstrb});
                    end
                end
            end
        end
    end

    // One access: queue expectations, hold the request until stall drops.
    task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] exp_rd,
                          input int exp_stall, input logic exp_txn,
                          input logic [31:0] exp_wdata, input logic [3:0] exp_wstrb);
        int stalls;
        bit done;
        mem_exp_t e;
        if (exp_txn) begin
            e.we = we; e.addr = {a[31:2], 2'b00}; e.wdata = exp_wdata; e.wstrb = exp_wstrb;
            exp_mem_q.push_back(e);
        end
        if (!we) exp_rd_q.push_back(exp_rd);
        req_valid = 1'b1; wr_en = we; addr = a; WriteData = wd; funct3 = f3;
        stalls = 0;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (stall) stalls++;
            else done = 1'b1;
            @(posedge clk); #1;
        end
        check("access_completes", {31'd0, done}, 32'd1);
        check("stall_cycles", stalls, exp_stall);
        req_valid = 1'b0; wr_en = 1'b0;
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_hits"}, hit_count, exp_hits);
        check({tag, "_misses"}, miss_count, exp_misses);
    endtask

    initial begin
        ld_vec_t vecs[12];
        vecs = '{
            '{F3_B,  32'h100, 32'h0000_0001}, '{F3_B,  32'h101, 32'h0000_007F},
            '{F3_B,  32'h102, 32'hFFFF_FFFF}, '{F3_B,  32'h103, 32'hFFFF_FF80},
            '{F3_BU, 32'h100, 32'h0000_0001}, '{F3_BU, 32'h101, 32'h0000_007F},
            '{F3_BU, 32'h102, 32'h0000_00FF}, '{F3_BU, 32'h103, 32'h0000_0080},
            '{F3_H,  32'h102, 32'hFFFF_80FF}, '{F3_HU, 32'h102, 32'h0000_80FF},
            '{F3_H,  32'h100, 32'h0000_7F01}, '{F3_W,  32'h102, 32'h80FF_7F01}
        };
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[32'h100 >> 2] = 32'hDEAD_BEEF;
        mem[32'h500 >> 2] = 32'h1234_5678;
        rst = 1'b1; req_valid = 1'b0; wr_en = 1'b0; addr = 32'h0;
        WriteData = 32'h0; funct3 = F3_W; mem_ready = 1'b0; mem_rdata = 32'h0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_readdata", ReadData, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_mem_req", {31'd0, mem_req}, 32'd0);
        check("reset_mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
        check_counts("reset");
        @(posedge clk); #1;

        // Cold miss then hit.
        access(1'b0, F3_W, 32'h100, 32'h0, 32'hDEAD_BEEF, 2, 1'b1, 32'h0, 4'h0);
        exp_misses++; check_counts("first_miss");
        access(1'b0, F3_W, 32'h100, 32'h0, 32'hDEAD_BEEF, 0, 1'b0, 32'h0, 4'h0);
        exp_hits++; check_counts("first_hit");

        // Store hit rewrites the line; lane extraction table follows.
        access(1'b1, F3_W, 32'h100, 32'h80FF_7F01, 32'h0, 2, 1'b1, 32'h80FF_7F01, 4'hF);
        foreach (vecs[i]) begin
            access(1'b0, vecs[i].f3, vecs[i].a, 32'h0, vecs[i].exp, 0, 1'b0, 32'h0, 4'h0);
            exp_hits++;
        end
        check_counts("lanes");

        // Byte store with a slow memory; line changes only on completion.
        lat = 3;
        access(1'b1, F3_B, 32'h101, 32'h1234_56AB, 32'h0, 4, 1'b1, 32'hABAB_ABAB, 4'b0010);
        lat = 1;
        access(1'b0, F3_W, 32'h100, 32'h0, 32'h80FF_AB01, 0, 1'b0, 32'h0, 4'h0);
        exp_hits++;

        // Store miss does not allocate.
        access(1'b1, F3_W, 32'h200, 32'hCAFE_F00D, 32'h0, 2, 1'b1, 32'hCAFE_F00D, 4'hF);
        access(1'b0, F3_W, 32'h200, 32'h0, 32'hCAFE_F00D, 2, 1'b1, 32'h0, 4'h0);
        exp_misses++; check_counts("no_allocate");

        // Index aliasing: 0x500 evicts 0x100.
        access(1'b0, F3_W, 32'h500, 32'h0, 32'h1234_5678, 2, 1'b1, 32'h0, 4'h0);
        access(1'b0, F3_W, 32'h100, 32'h0, 32'h80FF_AB01, 2, 1'b1, 32'h0, 4'h0);
        exp_misses += 2;
        access(1'b0, F3_W, 32'h100, 32'h0, 32'h80FF_AB01, 0, 1'b0, 32'h0, 4'h0);
        exp_hits++; check_counts("alias");

        // Halfword store hit on the upper half.
        access(1'b1, F3_H, 32'h202, 32'h1234_BEEF, 32'h0, 2, 1'b1, 32'hBEEF_BEEF, 4'b1100);
        access(1'b0, F3_W, 32'h200, 32'h0, 32'hBEEF_F00D, 0, 1'b0, 32'h0, 4'h0);
        exp_hits++; check_counts("half_store");

        // No request: no stall.
        @(negedge clk);
        check("idle_stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;

        // Reset in the middle of a fill that never gets acknowledged.
        lat = 1000;
        req_valid = 1'b1; wr_en = 1'b0; addr = 32'h300; funct3 = F3_W;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("fill_pending_stall", {31'd0, stall}, 32'd1);
        check("fill_pending_req", {31'd0, mem_req}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_stall", {31'd0, stall}, 32'd0);
        check("mid_rst_readdata", ReadData, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        check("abandon_mem_req", {31'd0, mem_req}, 32'd0);
        exp_hits = 0; exp_misses = 0;
        check_counts("after_rst");
        @(posedge clk); #1;
        lat = 1;
        access(1'b0, F3_W, 32'h100, 32'h0, 32'h80FF_AB01, 2, 1'b1, 32'h0, 4'h0);
        access(1'b0, F3_W, 32'h200, 32'h0, 32'hBEEF_F00D, 2, 1'b1, 32'h0, 4'h0);
        exp_misses += 2; check_counts("invalidated");

        repeat (2) @(posedge clk);
        check("load_queue_drained", exp_rd_q.size(), 32'd0);
        check("mem_queue_drained", exp_mem_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
